waveform_playback_sequencer: RTL and testbench
==============================================

Name: waveform_playback_sequencer

Overview:
- Generates the read-address stream for the dual-port waveform RAM that feeds the OSERDES function generator. One address per word_clock cycle.
- Plays a programmable word range, either looping forever or a set number of passes after a trigger.
- Emits a per-pass sync pulse delayed to line up with the RAM read latency, plus a blank flag so downstream logic can force an idle word while not playing.
- Sits between the SPI-written control registers and the RAM port-B address.

Parameters:
- ADDRESS_WIDTH, 14, width of word addresses into the waveform RAM.
- REPEAT_WIDTH, 8, width of repeat_count.
- SYNC_DELAY, 3, cycles from read_address presentation to sync_out assertion (RAM plus output register latency); legal range 1..8.

Ports:
- clock  input  1  word clock; all logic on posedge.
- reset  input  1  synchronous, active-high.
- start_address  input  ADDRESS_WIDTH  first word of range, inclusive.
- end_address  input  ADDRESS_WIDTH  end of range, exclusive.
- mode  input  1  0 = continuous loop; 1 = triggered burst.
- repeat_count  input  REPEAT_WIDTH  extra passes per burst (0 = one pass).
- trigger  input  1  starts a burst in mode 1.
- resync  input  1  restarts the current pass at start_address.
- read_address  output  ADDRESS_WIDTH  RAM port-B address.
- blank  output  1  high when the word at the aligned output is not part of playback.
- sync_out  output  1  one-cycle pulse aligned with the first word of each pass.
- busy  output  1  high in PLAYING.
- range_error  output  1  sticky; set when a pass is started with end_address <= start_address.

Behaviour:
- Reset values: read_address=0, blank=1, sync_out=0, busy=0, range_error=0, pass counter=0.
- Reset exit: the next state is PLAYING if mode=0, otherwise IDLE.
- Reset asserted mid-pass aborts the pass immediately.

States:
- IDLE:
  - read_address holds start_address; blank=1.
  - A trigger seen while mode=1 moves to PLAYING.
  - mode=0 moves to PLAYING on the next cycle.
- PLAYING:
  - read_address increments by 1 each cycle.
  - When read_address==last, or when resync=1, it reloads start_address.
  - The pass counter increments on each reload caused by reaching last; a reload caused by resync does not count as a completed pass.
- Leaving PLAYING:
  - mode=1 and completed passes == repeat_count+1 at wrap: go to IDLE; read_address=start_address.
  - mode changed to 1 while playing continuously: finish the current pass, then go to IDLE.

Pass latching:
- At each pass start (entry to PLAYING, wrap or resync), latch start_address and last=end_address-1 into internal registers.
- Register writes mid-pass take effect at the next pass boundary, never mid-pass.

Range error:
- If end_address <= start_address at pass start: set range_error, play no words and return to IDLE.
- In mode 0, retry each cycle until the range is valid; blank stays 1 throughout.
- Single-word range (end=start+1): read_address stays constant and a sync_out pulse occurs every cycle.

Sync and blank alignment:
- Internal sync_raw goes high the cycle read_address=start of a pass.
- sync_out = sync_raw delayed by SYNC_DELAY cycles through a shift register.
- blank = NOT busy, delayed by the same SYNC_DELAY, so blank is aligned with the RAM data.

Trigger handling:
- Trigger while PLAYING or while reset is high is ignored (no queueing).
- Trigger and resync asserted together in IDLE: start the burst; resync has no extra effect.
- Wrap and resync in the same cycle: a single reload, not counted as a completed pass.

Arithmetic:
- Address arithmetic is modulo 2^ADDRESS_WIDTH.
- end_address=0 means an empty range and raises range_error.
- The pass counter is REPEAT_WIDTH+1 bits wide so repeat_count=all-ones cannot overflow it.

Optional Feature:
- Macro: WAVEFORM_PLAYBACK_ASYNC_TRIGGER_EN.
- Defined: trigger is treated as asynchronous. It passes through a 2-flop synchronizer followed by rising-edge detection, and a burst starts 3 cycles after the rising edge. A trigger held high starts only one burst.
- Undefined: trigger is a synchronous level sampled directly, so a burst starts on the cycle after trigger is sampled high. A held trigger re-triggers immediately on return to IDLE.

Test Plan:
- Mode 0, start=16, end=20, SYNC_DELAY=3 -> read_address sequence 16,17,18,19,16,... and sync_out high exactly 3 cycles after each address 16.
- Mode 1, start=0, end=8, repeat_count=2, one trigger -> 24 addresses played, busy high for 24 cycles, then IDLE with read_address=0. A trigger mid-burst must be ignored.
- Mid-pass write: change end_address from 8 to 4 during a pass -> the current pass completes to 7, and the next pass wraps at 3.
- start=10, end=10 -> range_error=1, blank stays 1, no sync_out.
- Single-word range start=5, end=6 -> read_address stays 5 and sync_out pulses every cycle.
- Resync and reset:
  - Resync at address 13 of range 10..20 -> next address 10 and the pass count is unchanged.
  - Reset asserted mid-burst -> all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/waveform_playback_sequencer_if.sv
// Control/status bundle between the SPI register block and the waveform playback sequencer.
// The register side uses the master modport and the sequencer uses the slave modport.
interface waveform_playback_sequencer_if #(
  parameter int unsigned ADDRESS_WIDTH = 14,
  parameter int unsigned REPEAT_WIDTH  = 8
);
  logic [ADDRESS_WIDTH-1:0] start_address;
  logic [ADDRESS_WIDTH-1:0] end_address;
  logic                     mode;
  logic [REPEAT_WIDTH-1:0]  repeat_count;
  logic                     trigger;
  logic                     resync;
  logic [ADDRESS_WIDTH-1:0] read_address;
  logic                     blank;
  logic                     sync_out;
  logic                     busy;
  logic                     range_error;

  modport master (
    output start_address, end_address, mode, repeat_count, trigger, resync,
    input  read_address, blank, sync_out, busy, range_error
  );

  modport slave (
    input  start_address, end_address, mode, repeat_count, trigger, resync,
    output read_address, blank, sync_out, busy, range_error
  );
endinterface

// File: rtl/waveform_playback_sequencer.sv
// Read-address sequencer for the waveform RAM port B, with latency-aligned sync and blank.
// Optional macro WAVEFORM_PLAYBACK_ASYNC_TRIGGER_EN: synchronise and edge-detect the trigger.
module waveform_playback_sequencer #(
  parameter int unsigned ADDRESS_WIDTH = 14,
  parameter int unsigned REPEAT_WIDTH  = 8,
  parameter int unsigned SYNC_DELAY    = 3
) (
  input  logic                         clock,
  input  logic                         reset,
  waveform_playback_sequencer_if.slave bus
);

  localparam int unsigned PASS_WIDTH = REPEAT_WIDTH + 1;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PLAYING = 1'b1
  } state_e;

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [ADDRESS_WIDTH-1:0] last_q, last_d;
  logic [PASS_WIDTH-1:0]    pass_q, pass_d;
  logic                     burst_q, burst_d;
  logic                     sync_raw_q, sync_raw_d;
  logic                     range_err_q, range_err_d;
  logic                     busy_q;
  logic [SYNC_DELAY-1:0]    sync_sr_q;
  logic [SYNC_DELAY-1:0]    blank_sr_q;

  logic                     trig_evt_c;
  logic                     range_ok_c;
  logic                     at_last_c;
  logic                     wrap_c;
  logic [PASS_WIDTH-1:0]    pass_inc_c;
  logic                     burst_done_c;
  logic                     leave_c;

`ifdef WAVEFORM_PLAYBACK_ASYNC_TRIGGER_EN
  // Two-flop synchroniser plus edge detect; reset to ones so a level held through reset is not an edge.
  logic [2:0] trig_sync_q;
  logic       trig_evt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      trig_sync_q <= 3'b111;
      trig_evt_q  <= 1'b0;
    end else begin
      trig_sync_q <= {trig_sync_q[1:0], bus.trigger};
      trig_evt_q  <= trig_sync_q[1] & ~trig_sync_q[2];
    end
  end

  assign trig_evt_c = trig_evt_q;
`else
  assign trig_evt_c = bus.trigger;
`endif

  assign range_ok_c   = bus.end_address > bus.start_address;
  assign at_last_c    = addr_q == last_q;
  assign wrap_c       = at_last_c & ~bus.resync;
  assign pass_inc_c   = pass_q + PASS_WIDTH'(1);
  assign burst_done_c = pass_inc_c == (PASS_WIDTH'(bus.repeat_count) + PASS_WIDTH'(1));
  // A continuous loop ends when mode flips to burst; a burst ends after its last counted pass.
  assign leave_c      = wrap_c & (burst_q ? burst_done_c : bus.mode);

  // Next-state and pass bookkeeping.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    last_d      = last_q;
    pass_d      = pass_q;
    burst_d     = burst_q;
    sync_raw_d  = 1'b0;
    range_err_d = range_err_q;

    unique case (state_q)
      ST_IDLE: begin
        addr_d = bus.start_address;
        if (!bus.mode || trig_evt_c) begin
          if (range_ok_c) begin
            state_d    = ST_PLAYING;
            last_d     = bus.end_address - ADDRESS_WIDTH'(1);
            pass_d     = '0;
            burst_d    = bus.mode;
            sync_raw_d = 1'b1;
          end else begin
            range_err_d = 1'b1;
          end
        end
      end

      ST_PLAYING: begin
        if (bus.resync || at_last_c) begin
          addr_d = bus.start_address;
          if (wrap_c) begin
            pass_d = pass_inc_c;
          end
          if (leave_c) begin
            state_d = ST_IDLE;
          end else if (!range_ok_c) begin
            range_err_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            last_d     = bus.end_address - ADDRESS_WIDTH'(1);
            sync_raw_d = 1'b1;
          end
        end else begin
          addr_d = addr_q + ADDRESS_WIDTH'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      last_q      <= '0;
      pass_q      <= '0;
      burst_q     <= 1'b0;
      sync_raw_q  <= 1'b0;
      range_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      last_q      <= last_d;
      pass_q      <= pass_d;
      burst_q     <= burst_d;
      sync_raw_q  <= sync_raw_d;
      range_err_q <= range_err_d;
      busy_q      <= state_d == ST_PLAYING;
    end
  end

  // Delay sync and blank by the RAM read latency so they line up with the data word.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_sr_q  <= '0;
      blank_sr_q <= '1;
    end else begin
      sync_sr_q[0]  <= sync_raw_q;
      blank_sr_q[0] <= ~busy_q;
      for (int i = 1; i < int'(SYNC_DELAY); i++) begin
        sync_sr_q[i]  <= sync_sr_q[i-1];
        blank_sr_q[i] <= blank_sr_q[i-1];
      end
    end
  end

  assign bus.read_address = addr_q;
  assign bus.busy         = busy_q;
  assign bus.range_error  = range_err_q;
  assign bus.sync_out     = sync_sr_q[SYNC_DELAY-1];
  assign bus.blank        = blank_sr_q[SYNC_DELAY-1];

endmodule

// File: tb/tb_waveform_playback_sequencer.sv
// Scoreboard bench for waveform_playback_sequencer: expected words are queued with the stimulus
// and popped one per clock; sync/blank expectations are delayed through local history queues.
module tb_waveform_playback_sequencer;

  localparam int unsigned AW = 14;
  localparam int unsigned RW = 8;
  localparam int unsigned SD = 3;

  typedef struct {
    logic [AW-1:0] addr;
    logic          busy;
    logic          raw;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  waveform_playback_sequencer_if #(.ADDRESS_WIDTH(AW), .REPEAT_WIDTH(RW)) bus ();

  waveform_playback_sequencer #(
    .ADDRESS_WIDTH(AW),
    .REPEAT_WIDTH (RW),
    .SYNC_DELAY   (SD)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    bus.trigger = 1'b0;
    bus.resync  = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset            = 1'b1;
    bus.mode         = 1'b1;
    bus.start_address = AW'(7);
    bus.end_address  = AW'(9);
    bus.repeat_count = '0;
    bus.trigger      = 1'b0;
    bus.resync       = 1'b0;
    tick();
    tick();
    checks++;
    if ({bus.read_address, bus.blank, bus.sync_out, bus.busy, bus.range_error} !== {AW'(0), 4'b1000}) begin
      errors++;
      $display("FAIL reset_values: addr/blank/sync/busy/err got %0d/%b/%b/%b/%b expected 0/1/0/0/0",
               bus.read_address, bus.blank, bus.sync_out, bus.busy, bus.range_error);
    end
  endtask

  task automatic test_continuous();
    exp_t e;
    logic sh[$];
    logic bh[$];
    logic es, eb;
    int   n;
    do_reset();
    bus.mode          = 1'b0;
    bus.start_address = AW'(16);
    bus.end_address   = AW'(20);
    for (int k = 0; k < 3; k++)
      for (int a = 16; a < 20; a++) exp_q.push_back('{AW'(a), 1'b1, a == 16});
    for (int k = 0; k < 4; k++) exp_q.push_back('{AW'(16), 1'b0, 1'b0});
    for (int k = 0; k < int'(SD); k++) begin sh.push_back(1'b0); bh.push_back(1'b0); end
    reset = 1'b0;
    n = 0;
    while (exp_q.size() != 0) begin
      if (n == 9) bus.mode = 1'b1;
      tick();
      e = exp_q.pop_front();
      sh.push_back(e.raw);
      bh.push_back(e.busy);
      es = sh.pop_front();
      eb = ~bh.pop_front();
      checks++;
      if ({bus.read_address, bus.busy, bus.sync_out, bus.blank} !== {e.addr, e.busy, es, eb}) begin
        errors++;
        $display("FAIL continuous[%0d]: addr/busy/sync/blank got %0d/%b/%b/%b expected %0d/%b/%b/%b", n,
                 bus.read_address, bus.busy, bus.sync_out, bus.blank, e.addr, e.busy, es, eb);
      end
      n++;
    end
  endtask

  task automatic test_burst();
    exp_t e;
    logic sh[$];
    logic bh[$];
    logic es, eb;
    int   n;
    int   busy_cnt;
    do_reset();
    bus.mode          = 1'b1;
    bus.start_address = AW'(0);
    bus.end_address   = AW'(8);
    bus.repeat_count  = RW'(2);
    exp_q.push_back('{AW'(0), 1'b0, 1'b0});
    for (int k = 0; k < 24; k++) exp_q.push_back('{AW'(k % 8), 1'b1, (k % 8) == 0});
    for (int k = 0; k < 4; k++) exp_q.push_back('{AW'(0), 1'b0, 1'b0});
    for (int k = 0; k < int'(SD); k++) begin sh.push_back(1'b0); bh.push_back(1'b0); end
    reset    = 1'b0;
    n        = 0;
    busy_cnt = 0;
    while (exp_q.size() != 0) begin
      bus.trigger = (n == 1) || (n == 12);
      tick();
      if (bus.busy === 1'b1) busy_cnt++;
      e = exp_q.pop_front();
      sh.push_back(e.raw);
      bh.push_back(e.busy);
      es = sh.pop_front();
      eb = ~bh.pop_front();
      checks++;
      if ({bus.read_address, bus.busy, bus.sync_out, bus.blank} !== {e.addr, e.busy, es, eb}) begin
        errors++;
        $display("FAIL burst[%0d]: addr/busy/sync/blank got %0d/%b/%b/%b expected %0d/%b/%b/%b", n,
                 bus.read_address, bus.busy, bus.sync_out, bus.blank, e.addr, e.busy, es, eb);
      end
      n++;
    end
    checks++;
    if (busy_cnt != 24) begin
      errors++;
      $display("FAIL burst_busy_cycles: got %0d expected 24", busy_cnt);
    end
  endtask

  task automatic test_mid_pass_write();
    exp_t e;
    int   n;
    do_reset();
    bus.mode          = 1'b1;
    bus.start_address = AW'(0);
    bus.end_address   = AW'(8);
    bus.repeat_count  = RW'(1);
    exp_q.push_back('{AW'(0), 1'b0, 1'b0});
    for (int a = 0; a < 8; a++) exp_q.push_back('{AW'(a), 1'b1, a == 0});
    for (int a = 0; a < 4; a++) exp_q.push_back('{AW'(a), 1'b1, a == 0});
    for (int k = 0; k < 3; k++) exp_q.push_back('{AW'(0), 1'b0, 1'b0});
    reset = 1'b0;
    n = 0;
    while (exp_q.size() != 0) begin
      bus.trigger = (n == 1);
      if (n == 5) bus.end_address = AW'(4);
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({bus.read_address, bus.busy} !== {e.addr, e.busy}) begin
        errors++;
        $display("FAIL mid_pass_write[%0d]: addr/busy got %0d/%b expected %0d/%b", n,
                 bus.read_address, bus.busy, e.addr, e.busy);
      end
      n++;
    end
  endtask

  task automatic test_range_error();
    do_reset();
    bus.mode          = 1'b1;
    bus.start_address = AW'(10);
    bus.end_address   = AW'(10);
    reset = 1'b0;
    tick();
    checks++;
    if ({bus.read_address, bus.range_error} !== {AW'(10), 1'b0}) begin
      errors++;
      $display("FAIL range_pre: addr/err got %0d/%b expected 10/0", bus.read_address, bus.range_error);
    end
    bus.trigger = 1'b1;
    tick();
    bus.trigger = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k == 5) begin
        bus.mode        = 1'b0;
        bus.end_address = AW'(0);
      end
      checks++;
      if ({bus.busy, bus.blank, bus.sync_out, bus.range_error} !== 4'b0101) begin
        errors++;
        $display("FAIL range_error[%0d]: busy/blank/sync/err got %b/%b/%b/%b expected 0/1/0/1", k,
                 bus.busy, bus.blank, bus.sync_out, bus.range_error);
      end
      tick();
    end
    bus.end_address = AW'(12);
    tick();
    checks++;
    if ({bus.read_address, bus.busy, bus.range_error} !== {AW'(10), 2'b11}) begin
      errors++;
      $display("FAIL range_recover: addr/busy/err got %0d/%b/%b expected 10/1/1",
               bus.read_address, bus.busy, bus.range_error);
    end
  endtask

  task automatic test_single_word();
    exp_t e;
    logic sh[$];
    logic bh[$];
    logic es, eb;
    int   n;
    do_reset();
    bus.mode          = 1'b0;
    bus.start_address = AW'(5);
    bus.end_address   = AW'(6);
    for (int k = 0; k < 10; k++) exp_q.push_back('{AW'(5), 1'b1, 1'b1});
    for (int k = 0; k < int'(SD); k++) begin sh.push_back(1'b0); bh.push_back(1'b0); end
    reset = 1'b0;
    n = 0;
    while (exp_q.size() != 0) begin
      tick();
      e = exp_q.pop_front();
      sh.push_back(e.raw);
      bh.push_back(e.busy);
      es = sh.pop_front();
      eb = ~bh.pop_front();
      checks++;
      if ({bus.read_address, bus.busy, bus.sync_out, bus.blank} !== {e.addr, e.busy, es, eb}) begin
        errors++;
        $display("FAIL single_word[%0d]: addr/busy/sync/blank got %0d/%b/%b/%b expected %0d/%b/%b/%b", n,
                 bus.read_address, bus.busy, bus.sync_out, bus.blank, e.addr, e.busy, es, eb);
      end
      n++;
    end
  endtask

  task automatic test_resync();
    exp_t e;
    logic sh[$];
    logic es;
    int   n;
    do_reset();
    bus.mode          = 1'b1;
    bus.start_address = AW'(10);
    bus.end_address   = AW'(20);
    bus.repeat_count  = RW'(0);
    exp_q.push_back('{AW'(10), 1'b0, 1'b0});
    for (int a = 10; a < 14; a++) exp_q.push_back('{AW'(a), 1'b1, a == 10});
    for (int k = 0; k < 2; k++)
      for (int a = 10; a < 20; a++) exp_q.push_back('{AW'(a), 1'b1, a == 10});
    for (int k = 0; k < 4; k++) exp_q.push_back('{AW'(10), 1'b0, 1'b0});
    for (int k = 0; k < int'(SD); k++) sh.push_back(1'b0);
    reset = 1'b0;
    n = 0;
    while (exp_q.size() != 0) begin
      bus.trigger = (n == 1);
      bus.resync  = (n == 1) || (n == 5) || (n == 15);
      tick();
      e = exp_q.pop_front();
      sh.push_back(e.raw);
      es = sh.pop_front();
      checks++;
      if ({bus.read_address, bus.busy, bus.sync_out} !== {e.addr, e.busy, es}) begin
        errors++;
        $display("FAIL resync[%0d]: addr/busy/sync got %0d/%b/%b expected %0d/%b/%b", n,
                 bus.read_address, bus.busy, bus.sync_out, e.addr, e.busy, es);
      end
      n++;
    end
    bus.resync = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    bus.mode          = 1'b1;
    bus.start_address = AW'(0);
    bus.end_address   = AW'(0);
    bus.repeat_count  = RW'(3);
    reset = 1'b0;
    tick();
    bus.trigger = 1'b1;
    tick();
    bus.end_address = AW'(8);
    tick();
    bus.trigger = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    checks++;
    if ({bus.read_address, bus.busy, bus.blank, bus.range_error} !== {AW'(5), 3'b101}) begin
      errors++;
      $display("FAIL pre_reset: addr/busy/blank/err got %0d/%b/%b/%b expected 5/1/0/1",
               bus.read_address, bus.busy, bus.blank, bus.range_error);
    end
    reset       = 1'b1;
    bus.trigger = 1'b1;
    tick();
    checks++;
    if ({bus.read_address, bus.blank, bus.sync_out, bus.busy, bus.range_error} !== {AW'(0), 4'b1000}) begin
      errors++;
      $display("FAIL reset_mid_burst: addr/blank/sync/busy/err got %0d/%b/%b/%b/%b expected 0/1/0/0/0",
               bus.read_address, bus.blank, bus.sync_out, bus.busy, bus.range_error);
    end
    tick();
    reset       = 1'b0;
    bus.trigger = 1'b0;
    tick();
    tick();
    checks++;
    if ({bus.read_address, bus.busy} !== {AW'(0), 1'b0}) begin
      errors++;
      $display("FAIL trigger_in_reset: addr/busy got %0d/%b expected 0/0", bus.read_address, bus.busy);
    end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_burst();
    test_mid_pass_write();
    test_range_error();
    test_single_word();
    test_resync();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
